// File: rtl/ram_port_master_if.sv
// Bundle of request/response streams, init status and RAM port for ram_port_master.
// The master modport is the ram_port_master view; slave is the client-plus-RAM side.
interface ram_port_master_if #(
    parameter int DATAWIDTH = 2,
    parameter int ADDRWIDTH = 2
);
    logic                 ReqValid;
    logic                 ReqReady;
    logic                 ReqWrite;
    logic [ADDRWIDTH-1:0] ReqAddr;
    logic [DATAWIDTH-1:0] ReqWData;
    logic                 RspValid;
    logic                 RspReady;
    logic [DATAWIDTH-1:0] RspData;
    logic                 InitDone;
    logic [ADDRWIDTH-1:0] RamAddr;
    logic [DATAWIDTH-1:0] RamDataIn;
    logic                 RamWriteEnable;
    logic [DATAWIDTH-1:0] RamDataOut;

    modport master (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData, RspReady, RamDataOut,
        output ReqReady, RspValid, RspData, InitDone, RamAddr, RamDataIn, RamWriteEnable
    );

    modport slave (
        output ReqValid, ReqWrite, ReqAddr, ReqWData, RspReady, RamDataOut,
        input  ReqReady, RspValid, RspData, InitDone, RamAddr, RamDataIn, RamWriteEnable
    );
endinterface

// File: rtl/ram_port_master.sv
// Initiator for a single-port synchronous RAM with 1-cycle read latency.
// Turns a valid/ready request stream into RAM cycles, returns read data in order
// through a small show-ahead FIFO, and optionally zero-fills the RAM after reset.
module ram_port_master #(
    parameter int DATAWIDTH = 2,
    parameter int ADDRWIDTH = 2,
    parameter int RSP_DEPTH = 2,
    parameter bit INIT_EN   = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    ram_port_master_if.master bus
);
    localparam int MEMDEPTH = 2 ** ADDRWIDTH;
    localparam int PTRW     = $clog2(RSP_DEPTH);
    localparam int CNTW     = $clog2(RSP_DEPTH + 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    typedef logic [CNTW:0] use_t;

    state_t               state_q, state_d;
    logic [ADDRWIDTH-1:0] init_cnt_q;
    logic [ADDRWIDTH-1:0] ram_addr_q;
    logic [ADDRWIDTH-1:0] ram_addr;
    logic [DATAWIDTH-1:0] ram_wdata;
    logic                 ram_we;
    logic                 req_ready;
    logic                 req_accept;
    logic                 rd_accept;
    logic                 rd_pending_q;
    logic                 rsp_valid;
    logic                 rsp_pop;
    logic                 credit_ok;
    logic [DATAWIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PTRW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]      count_q;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(RSP_DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    assign rsp_valid = (count_q != '0);
    assign rsp_pop   = rsp_valid & bus.RspReady;
    // A read slot is free once the entry popped this cycle is counted as gone,
    // which keeps one read per cycle flowing while the consumer is ready.
    assign credit_ok = (use_t'(count_q) + use_t'(rd_pending_q) - use_t'(rsp_pop))
                       < use_t'(RSP_DEPTH);

    // Next state, request handshake and RAM port drive.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        req_ready  = 1'b0;
        req_accept = 1'b0;
        rd_accept  = 1'b0;
        ram_we     = 1'b0;
        ram_wdata  = '0;
        ram_addr   = ram_addr_q;
        if (Reset) begin
            ram_addr = '0;
        end else begin
            unique case (state_q)
                ST_INIT: begin
                    ram_we   = 1'b1;
                    ram_addr = init_cnt_q;
                    if (init_cnt_q == ADDRWIDTH'(MEMDEPTH - 1)) state_d = ST_RUN;
                end
                ST_RUN: begin
                    req_ready  = bus.ReqWrite | credit_ok;
                    req_accept = bus.ReqValid & req_ready;
                    rd_accept  = req_accept & ~bus.ReqWrite;
                    if (req_accept) begin
                        ram_addr  = bus.ReqAddr;
                        ram_we    = bus.ReqWrite;
                        ram_wdata = bus.ReqWrite ? bus.ReqWData : '0;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Control state: FSM, sweep counter, held address, read capture and FIFO pointers.
    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            state_q      <= INIT_EN ? ST_INIT : ST_RUN;
            init_cnt_q   <= '0;
            ram_addr_q   <= '0;
            rd_pending_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + ADDRWIDTH'(1);
            ram_addr_q   <= ram_addr;
            rd_pending_q <= rd_accept;
            if (rd_pending_q) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (rsp_pop)      rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q      <= count_q + CNTW'(rd_pending_q) - CNTW'(rsp_pop);
        end
    end

    // Response storage: captures RamDataOut the edge after a read was issued.
    always_ff @(posedge Clk) begin
        // NOTE: the FIFO words are cleared on reset so RspData reads 0 until the first response.
        if (Reset) begin
            for (int i = 0; i < RSP_DEPTH; i++) fifo_mem[i] <= '0;
        end else if (rd_pending_q) begin
            fifo_mem[wr_ptr_q] <= bus.RamDataOut;
        end
    end

    assign bus.ReqReady       = req_ready;
    assign bus.RspValid       = rsp_valid;
    assign bus.RspData        = fifo_mem[rd_ptr_q];
    assign bus.InitDone       = (state_q == ST_RUN) & ~Reset;
    assign bus.RamAddr        = ram_addr;
    assign bus.RamDataIn      = ram_wdata;
    assign bus.RamWriteEnable = ram_we;
endmodule

// File: tb/tb_ram_port_master.sv
// Self-checking bench for ram_port_master with a behavioural RAM and a
// transaction-level reference model (memory array plus timed response queue).
module tb_ram_port_master;
    localparam int DW = 2;
    localparam int AW = 2;
    localparam int RD = 2;
    localparam int MD = 1 << AW;

    typedef struct {
        logic [DW-1:0] data;
        int            avail;
    } rsp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    ram_port_master_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

    ram_port_master #(
        .DATAWIDTH(DW), .ADDRWIDTH(AW), .RSP_DEPTH(RD), .INIT_EN(1'b1)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.master)
    );

    // Behavioural single-port RAM: write cycles leave the read register alone.
    logic [DW-1:0] ram [MD];
    always @(posedge Clk) begin
        if (bus.RamWriteEnable) ram[bus.RamAddr] <= bus.RamDataIn;
        else                    bus.RamDataOut   <= ram[bus.RamAddr];
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [MD];
    rsp_t          rsp_q [$];
    logic [AW-1:0] last_addr;
    int            edge_cnt;
    int            total = 0;
    int            bad   = 0;

    task automatic set_idle;
        bus.ReqValid = 1'b0;
        bus.ReqWrite = 1'b0;
        bus.ReqAddr  = '0;
        bus.ReqWData = '0;
        bus.RspReady = 1'b0;
    endtask

    // One clock of stimulus, checked against the model; returns what the DUT showed.
    task automatic drive_cycle(input logic v, input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic rr,
                               output logic o_ready, output logic o_valid,
                               output logic [DW-1:0] o_data);
        int            outst;
        logic          e_valid, e_pop, e_ready, e_acc;
        logic [AW-1:0] e_addr;
        rsp_t          r;
        @(negedge Clk);
        bus.ReqValid = v;
        bus.ReqWrite = w;
        bus.ReqAddr  = a;
        bus.ReqWData = d;
        bus.RspReady = rr;
        #1;
        outst   = rsp_q.size();
        e_valid = (outst > 0) && (rsp_q[0].avail <= edge_cnt);
        e_pop   = e_valid && rr;
        e_ready = w || ((outst - int'(e_pop)) < RD);
        e_acc   = v && e_ready;
        e_addr  = e_acc ? a : last_addr;
        o_ready = bus.ReqReady;
        o_valid = bus.RspValid;
        o_data  = bus.RspData;
        total++;
        if (bus.ReqReady !== e_ready) begin
            bad++; $display("FAIL req_ready t=%0t got=%b exp=%b", $time, bus.ReqReady, e_ready);
        end
        total++;
        if (bus.RspValid !== e_valid) begin
            bad++; $display("FAIL rsp_valid t=%0t got=%b exp=%b", $time, bus.RspValid, e_valid);
        end
        if (e_valid) begin
            total++;
            if (bus.RspData !== rsp_q[0].data) begin
                bad++; $display("FAIL rsp_data t=%0t got=%0h exp=%0h", $time, bus.RspData, rsp_q[0].data);
            end
        end
        total++;
        if (bus.InitDone !== 1'b1) begin
            bad++; $display("FAIL init_done t=%0t got=%b exp=1", $time, bus.InitDone);
        end
        total++;
        if (bus.RamWriteEnable !== (e_acc && w)) begin
            bad++; $display("FAIL ram_we t=%0t got=%b exp=%b", $time, bus.RamWriteEnable, e_acc && w);
        end
        total++;
        if (bus.RamAddr !== e_addr) begin
            bad++; $display("FAIL ram_addr t=%0t got=%0h exp=%0h", $time, bus.RamAddr, e_addr);
        end
        if (e_acc && w) begin
            total++;
            if (bus.RamDataIn !== d) begin
                bad++; $display("FAIL ram_wdata t=%0t got=%0h exp=%0h", $time, bus.RamDataIn, d);
            end
        end
        @(posedge Clk);
        if (e_pop) void'(rsp_q.pop_front());
        if (e_acc) begin
            if (w) begin
                ref_mem[a] = d;
            end else begin
                r.data  = ref_mem[a];
                r.avail = edge_cnt + 2;
                rsp_q.push_back(r);
            end
            last_addr = a;
        end
        edge_cnt++;
    endtask

    // Holds Reset over one edge (caller is between negedge and posedge) and checks reset values.
    task automatic do_reset_checked(input string tag);
        Reset = 1'b1;
        set_idle();
        @(posedge Clk);
        @(negedge Clk);
        #1;
        total++; if (bus.ReqReady !== 1'b0) begin bad++; $display("FAIL %s_req_ready got=%b exp=0", tag, bus.ReqReady); end
        total++; if (bus.RspValid !== 1'b0) begin bad++; $display("FAIL %s_rsp_valid got=%b exp=0", tag, bus.RspValid); end
        total++; if (bus.RspData !== '0) begin bad++; $display("FAIL %s_rsp_data got=%0h exp=0", tag, bus.RspData); end
        total++; if (bus.InitDone !== 1'b0) begin bad++; $display("FAIL %s_init_done got=%b exp=0", tag, bus.InitDone); end
        total++; if (bus.RamWriteEnable !== 1'b0) begin bad++; $display("FAIL %s_ram_we got=%b exp=0", tag, bus.RamWriteEnable); end
        total++; if (bus.RamAddr !== '0) begin bad++; $display("FAIL %s_ram_addr got=%0h exp=0", tag, bus.RamAddr); end
        total++; if (bus.RamDataIn !== '0) begin bad++; $display("FAIL %s_ram_wdata got=%0h exp=0", tag, bus.RamDataIn); end
        Reset = 1'b0;
    endtask

    // Full clear sweep straight after reset release; requests offered meanwhile must be held off.
    task automatic test_init_sweep;
        bus.ReqValid = 1'b1;
        bus.ReqWrite = 1'b1;
        bus.ReqAddr  = AW'(1);
        bus.ReqWData = DW'(3);
        for (int i = 0; i < MD; i++) begin
            #1;
            total++; if (bus.RamWriteEnable !== 1'b1) begin bad++; $display("FAIL sweep_we i=%0d got=%b exp=1", i, bus.RamWriteEnable); end
            total++; if (bus.RamAddr !== AW'(i)) begin bad++; $display("FAIL sweep_addr i=%0d got=%0h exp=%0h", i, bus.RamAddr, i); end
            total++; if (bus.RamDataIn !== '0) begin bad++; $display("FAIL sweep_data i=%0d got=%0h exp=0", i, bus.RamDataIn); end
            total++; if (bus.ReqReady !== 1'b0) begin bad++; $display("FAIL sweep_ready i=%0d got=%b exp=0", i, bus.ReqReady); end
            total++; if (bus.InitDone !== 1'b0) begin bad++; $display("FAIL sweep_done i=%0d got=%b exp=0", i, bus.InitDone); end
            @(negedge Clk);
        end
        set_idle();
        #1;
        total++; if (bus.InitDone !== 1'b1) begin bad++; $display("FAIL init_done_after got=%b exp=1", bus.InitDone); end
        total++; if (bus.ReqReady !== 1'b1) begin bad++; $display("FAIL ready_after got=%b exp=1", bus.ReqReady); end
        total++; if (bus.RamWriteEnable !== 1'b0) begin bad++; $display("FAIL we_after got=%b exp=0", bus.RamWriteEnable); end
        total++; if (bus.RspValid !== 1'b0) begin bad++; $display("FAIL fifo_empty_after got=%b exp=0", bus.RspValid); end
        for (int i = 0; i < MD; i++) ref_mem[i] = '0;
        rsp_q.delete();
        last_addr = AW'(MD - 1);
        edge_cnt  = 0;
    endtask

    task automatic test_reset;
        set_idle();
        do_reset_checked("reset");
        test_init_sweep();
    endtask

    task automatic test_write_read;
        logic rdy, vld; logic [DW-1:0] dat;
        drive_cycle(1'b1, 1'b1, AW'(2), DW'(3), 1'b1, rdy, vld, dat);
        drive_cycle(1'b1, 1'b0, AW'(2), '0, 1'b1, rdy, vld, dat);
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL wr_rd_accept got=%b exp=1", rdy); end
        drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, rdy, vld, dat);
        total++; if (vld !== 1'b0) begin bad++; $display("FAIL wr_rd_early got=%b exp=0", vld); end
        drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, rdy, vld, dat);
        total++; if (vld !== 1'b1 || dat !== DW'(3)) begin bad++; $display("FAIL wr_rd_data got=%b/%0h exp=1/3", vld, dat); end
    endtask

    task automatic test_read_then_write;
        logic rdy, vld; logic [DW-1:0] dat;
        logic [DW-1:0] got [$];
        for (int c = 0; c < 8; c++) begin
            case (c)
                0:       drive_cycle(1'b1, 1'b1, AW'(1), DW'(1), 1'b1, rdy, vld, dat);
                1:       drive_cycle(1'b1, 1'b0, AW'(1), '0,     1'b1, rdy, vld, dat);
                2:       drive_cycle(1'b1, 1'b1, AW'(1), DW'(2), 1'b1, rdy, vld, dat);
                3:       drive_cycle(1'b1, 1'b0, AW'(1), '0,     1'b1, rdy, vld, dat);
                default: drive_cycle(1'b0, 1'b0, '0,     '0,     1'b1, rdy, vld, dat);
            endcase
            if (vld === 1'b1) got.push_back(dat);
        end
        total++;
        if (got.size() != 2) begin
            bad++; $display("FAIL rtw_count got=%0d exp=2", got.size());
        end else begin
            total++; if (got[0] !== DW'(1)) begin bad++; $display("FAIL rtw_old got=%0h exp=1", got[0]); end
            total++; if (got[1] !== DW'(2)) begin bad++; $display("FAIL rtw_new got=%0h exp=2", got[1]); end
        end
    endtask

    task automatic test_backpressure;
        logic rdy, vld; logic [DW-1:0] dat;
        logic [DW-1:0] got [$];
        int acc = 0;
        drive_cycle(1'b1, 1'b1, AW'(0), DW'(2), 1'b0, rdy, vld, dat);
        drive_cycle(1'b1, 1'b1, AW'(1), DW'(1), 1'b0, rdy, vld, dat);
        drive_cycle(1'b1, 1'b1, AW'(2), DW'(3), 1'b0, rdy, vld, dat);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0, AW'(i), '0, 1'b0, rdy, vld, dat);
            if (rdy === 1'b1) acc++;
        end
        total++; if (acc != 2) begin bad++; $display("FAIL bp_reads_accepted got=%0d exp=2", acc); end
        drive_cycle(1'b1, 1'b1, AW'(3), DW'(1), 1'b0, rdy, vld, dat);
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL bp_write_ready got=%b exp=1", rdy); end
        drive_cycle(1'b1, 1'b0, AW'(3), '0, 1'b0, rdy, vld, dat);
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL bp_read_blocked got=%b exp=0", rdy); end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, rdy, vld, dat);
            if (vld === 1'b1) got.push_back(dat);
        end
        total++;
        if (got.size() != 2) begin
            bad++; $display("FAIL bp_drain_count got=%0d exp=2", got.size());
        end else begin
            total++; if (got[0] !== DW'(2) || got[1] !== DW'(1)) begin
                bad++; $display("FAIL bp_order got=%0h,%0h exp=2,1", got[0], got[1]);
            end
        end
    endtask

    task automatic test_streaming;
        logic rdy, vld; logic [DW-1:0] dat;
        logic [DW-1:0] vals [MD];
        int            hit_cyc [$];
        logic [DW-1:0] hit_dat [$];
        for (int i = 0; i < MD; i++) begin
            vals[i] = DW'(MD - 1 - i);
            drive_cycle(1'b1, 1'b1, AW'(i), vals[i], 1'b1, rdy, vld, dat);
        end
        for (int c = 0; c < MD + 4; c++) begin
            if (c < MD) begin
                drive_cycle(1'b1, 1'b0, AW'(c), '0, 1'b1, rdy, vld, dat);
                total++; if (rdy !== 1'b1) begin bad++; $display("FAIL stream_ready c=%0d got=%b exp=1", c, rdy); end
            end else begin
                drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, rdy, vld, dat);
            end
            if (vld === 1'b1) begin
                hit_cyc.push_back(c);
                hit_dat.push_back(dat);
            end
        end
        total++;
        if (hit_cyc.size() != MD) begin
            bad++; $display("FAIL stream_count got=%0d exp=%0d", hit_cyc.size(), MD);
        end else begin
            for (int i = 0; i < MD; i++) begin
                total++;
                if (hit_cyc[i] != 2 + i || hit_dat[i] !== vals[i]) begin
                    bad++; $display("FAIL stream_rsp i=%0d cyc=%0d data=%0h exp_cyc=%0d exp_data=%0h",
                                    i, hit_cyc[i], hit_dat[i], 2 + i, vals[i]);
                end
            end
        end
    endtask

    task automatic test_random;
        logic rdy, vld; logic [DW-1:0] dat;
        for (int c = 0; c < 400; c++) begin
            drive_cycle($urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom), DW'($urandom),
                        $urandom_range(0, 3) != 0, rdy, vld, dat);
        end
        for (int c = 0; c < 6; c++) drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, rdy, vld, dat);
        total++; if (rsp_q.size() != 0 || bus.RspValid !== 1'b0) begin
            bad++; $display("FAIL random_drain got=%b exp=0", bus.RspValid);
        end
    endtask

    task automatic test_reset_mid;
        logic rdy, vld; logic [DW-1:0] dat;
        // A read in flight when Reset arrives must never surface.
        drive_cycle(1'b1, 1'b0, AW'(0), '0, 1'b1, rdy, vld, dat);
        @(negedge Clk);
        do_reset_checked("mid_read");
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (bus.RamAddr !== AW'(i) || bus.RamWriteEnable !== 1'b1) begin
                bad++; $display("FAIL mid_sweep i=%0d got=%0h/%b exp=%0h/1", i, bus.RamAddr, bus.RamWriteEnable, i);
            end
            @(negedge Clk);
        end
        #1;
        total++; if (bus.RamAddr !== AW'(2)) begin bad++; $display("FAIL mid_at2 got=%0h exp=2", bus.RamAddr); end
        do_reset_checked("mid_sweep");
        test_init_sweep();
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, rdy, vld, dat);
            total++; if (vld !== 1'b0) begin bad++; $display("FAIL mid_no_rsp c=%0d got=%b exp=0", c, vld); end
        end
        drive_cycle(1'b1, 1'b0, AW'(1), '0, 1'b1, rdy, vld, dat);
        for (int c = 0; c < 3; c++) drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, rdy, vld, dat);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_then_write();
        test_backpressure();
        test_streaming();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
